// File: rtl/bist_pattern_engine_if.sv
// Handshake bundle between the test-access top level (master) and the BIST
// pattern engine (slave).
interface bist_pattern_engine_if #(
  parameter int W = 8
);
  logic         START;
  logic         ABORT;
  logic [W-1:0] DUT_RESP;
  logic [W-1:0] PATTERN;
  logic         OUT;
  logic         RUNNING;
  logic         BIST_END;
  logic         PASS;
  logic [W-1:0] SIGNATURE;

  modport master (
    output START, ABORT, DUT_RESP,
    input  PATTERN, OUT, RUNNING, BIST_END, PASS, SIGNATURE
  );

  modport slave (
    input  START, ABORT, DUT_RESP,
    output PATTERN, OUT, RUNNING, BIST_END, PASS, SIGNATURE
  );
endinterface

// File: rtl/bist_pattern_engine.sv
// BIST sequencer: M_SESSIONS sessions of N_CYCLES cycles, Galois-LFSR patterns
// out, MISR compaction of responses in, golden-signature compare at the end.
module bist_pattern_engine #(
  parameter int           W          = 8,
  parameter int           N_CYCLES   = 9,
  parameter int           M_SESSIONS = 10,
  parameter logic [W-1:0] LFSR_POLY  = 8'h1D,
  parameter logic [W-1:0] LFSR_SEED  = 8'h01,
  parameter logic [W-1:0] MISR_POLY  = 8'h1D,
  parameter logic [W-1:0] GOLDEN_SIG = 8'h00
) (
  input logic                CLK,
  input logic                RESET,
  bist_pattern_engine_if.slave bus
);

  localparam int CW = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
  localparam int SW = (M_SESSIONS > 1) ? $clog2(M_SESSIONS) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(N_CYCLES - 1);
  localparam logic [SW-1:0] SESS_LAST = SW'(M_SESSIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] sess_q, sess_d;
  logic [W-1:0]  lfsr_q, lfsr_d;
  logic [W-1:0]  misr_q, misr_d;
  logic          pass_q, pass_d;
  logic          start_q, start_d;
  logic          armed_q, armed_d;
  logic          start_edge_s;
  logic          last_cyc_s;

  function automatic logic [W-1:0] galois_step(input logic [W-1:0] v,
                                                input logic [W-1:0] poly);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? poly : {W{1'b0}});
  endfunction

  // State, counters, LFSR/MISR and START history registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cyc_q   <= {CW{1'b0}};
      sess_q  <= {SW{1'b0}};
      lfsr_q  <= LFSR_SEED;
      misr_q  <= {W{1'b0}};
      pass_q  <= 1'b0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sess_q  <= sess_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      pass_q  <= pass_d;
      start_q <= start_d;
      armed_q <= armed_d;
    end
  end

  // armed_q blocks a START that was already high when reset released from
  // looking like a fresh 0->1 edge; it sets once START has been seen low.
  assign start_edge_s = bus.START & ~start_q & armed_q;
  assign last_cyc_s   = (cyc_q == CYC_LAST);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sess_d  = sess_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    pass_d  = pass_q;
    start_d = bus.START;
    armed_d = armed_q | ~bus.START;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && bus.ABORT) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (start_edge_s && !bus.ABORT) begin
          state_d = S_RUN;
          cyc_d   = {CW{1'b0}};
          sess_d  = {SW{1'b0}};
          lfsr_d  = LFSR_SEED;
          misr_d  = {W{1'b0}};
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          lfsr_d = galois_step(lfsr_q, LFSR_POLY);
          // The last cycle of a session is a non-capture slot.
          if (!last_cyc_s) begin
            misr_d = galois_step(misr_q, MISR_POLY) ^ bus.DUT_RESP;
            cyc_d  = cyc_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cyc_d = {CW{1'b0}};
            if (sess_q == SESS_LAST) begin
              sess_d  = {SW{1'b0}};
              state_d = S_DONE;
              pass_d  = (misr_q == GOLDEN_SIG);
            end else begin
              sess_d = sess_q + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  assign bus.RUNNING   = (state_q == S_RUN);
  assign bus.BIST_END  = (state_q == S_DONE);
  assign bus.OUT       = (state_q == S_RUN) && !last_cyc_s;
  assign bus.PATTERN   = (state_q == S_RUN) ? lfsr_q : {W{1'b0}};
  assign bus.PASS      = pass_q;
  assign bus.SIGNATURE = misr_q;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench: scoreboard-driven full runs on the default engine, a
// golden-matched twin for loopback, and a vector table on a tiny W=4 engine.
module tb_bist_pattern_engine;

  typedef struct packed {
    logic [7:0] pat;
    logic       out;
    logic       run;
    logic       bend;
    logic       pass;
    logic [7:0] sig;
  } obs_t;

  typedef struct {
    logic       st;
    logic       ab;
    logic [3:0] pat;
    logic       out;
    logic       run;
    logic       bend;
    logic       pass;
    logic [3:0] sig;
  } vec_t;

  function automatic logic [7:0] gstep(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] loop_sig();
    logic [7:0] l;
    logic [7:0] m;
    l = 8'h01;
    m = 8'h00;
    for (int k = 0; k < 90; k++) begin
      if ((k % 9) != 8) m = gstep(m) ^ l;
      l = gstep(l);
    end
    return m;
  endfunction

  localparam logic [7:0] LOOP_SIG = loop_sig();

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic lb = 1'b0;
  logic s_start = 1'b0;
  logic s_abort = 1'b0;

  int checks = 0;
  int failures = 0;
  obs_t exp_q[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  bist_pattern_engine_if #(.W(8)) if0 ();
  bist_pattern_engine_if #(.W(8)) ifg ();
  bist_pattern_engine_if #(.W(4)) ifs ();

  assign if0.START    = start;
  assign if0.ABORT    = abort;
  assign if0.DUT_RESP = lb ? if0.PATTERN : 8'h00;
  assign ifg.START    = start;
  assign ifg.ABORT    = abort;
  assign ifg.DUT_RESP = lb ? ifg.PATTERN : 8'h00;
  assign ifs.START    = s_start;
  assign ifs.ABORT    = s_abort;
  assign ifs.DUT_RESP = 4'hA;

  bist_pattern_engine u0 (.CLK(clk), .RESET(rst), .bus(if0.slave));
  bist_pattern_engine #(.GOLDEN_SIG(LOOP_SIG)) ug (.CLK(clk), .RESET(rst), .bus(ifg.slave));
  bist_pattern_engine #(
    .W(4), .N_CYCLES(2), .M_SESSIONS(1),
    .LFSR_POLY(4'h3), .LFSR_SEED(4'h1), .MISR_POLY(4'h3), .GOLDEN_SIG(4'hA)
  ) us (.CLK(clk), .RESET(rst), .bus(ifs.slave));

  function automatic obs_t sample0();
    return {if0.PATTERN, if0.OUT, if0.RUNNING, if0.BIST_END, if0.PASS, if0.SIGNATURE};
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got pat=%h out=%b run=%b end=%b pass=%b sig=%h, required pat=%h out=%b run=%b end=%b pass=%b sig=%h",
               name, got.pat, got.out, got.run, got.bend, got.pass, got.sig,
               exp.pat, exp.out, exp.run, exp.bend, exp.pass, exp.sig);
    end
  endtask

  task automatic tick_and_score(input string name);
    obs_t e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got pat=%h required an expectation", name, if0.PATTERN);
    end else begin
      e = exp_q.pop_front();
      check_obs(name, sample0(), e);
    end
  endtask

  // One run on the default engine; abort_at < 0 means no abort.
  task automatic run_main(input bit loop_en, input int abort_at, input bit hold,
                          input string name, output obs_t last_o);
    logic [7:0] ml;
    logic [7:0] mm;
    obs_t done_e;
    lb = loop_en;
    ml = 8'h01;
    mm = 8'h00;
    start = 1'b1;
    exp_q.push_back({ml, 1'b1, 1'b1, 1'b0, 1'b0, mm});
    tick_and_score({name, "_c0"});
    start = hold;
    for (int k = 1; k < 90; k++) begin
      if ((k - 1) == abort_at) begin
        abort = 1'b1;
        exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mm});
        tick_and_score({name, "_abort"});
        abort = 1'b0;
        last_o = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mm};
        return;
      end
      if (((k - 1) % 9) != 8) mm = gstep(mm) ^ (loop_en ? ml : 8'h00);
      ml = gstep(ml);
      exp_q.push_back({ml, ((k % 9) != 8), 1'b1, 1'b0, 1'b0, mm});
      tick_and_score({name, "_run"});
    end
    done_e = {8'h00, 1'b0, 1'b0, 1'b1, (mm == 8'h00), mm};
    for (int d = 0; d < 3; d++) begin
      exp_q.push_back(done_e);
      tick_and_score({name, "_done"});
      if (d == 0) begin
        checks++;
        if (ifg.BIST_END !== 1'b1 || ifg.PASS !== (mm == LOOP_SIG)) begin
          failures++;
          $display("FAIL %s_golden: got end=%b pass=%b, required end=1 pass=%b",
                   name, ifg.BIST_END, ifg.PASS, (mm == LOOP_SIG));
        end
      end
    end
    last_o = done_e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t last;
    logic [11:0] got_s;
    logic [11:0] exp_s;

    tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[9]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[12] = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[13] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_obs("reset_state", sample0(), '0);
    rst = 1'b0;

    // Short engine: 2-cycle single session, driven from the vector table.
    for (int i = 0; i < 14; i++) begin
      s_start = tbl[i].st;
      s_abort = tbl[i].ab;
      @(posedge clk);
      @(negedge clk);
      got_s = {ifs.PATTERN, ifs.OUT, ifs.RUNNING, ifs.BIST_END, ifs.PASS, ifs.SIGNATURE};
      exp_s = {tbl[i].pat, tbl[i].out, tbl[i].run, tbl[i].bend, tbl[i].pass, tbl[i].sig};
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL small_vec%0d: got {pat,out,run,end,pass,sig}=%h, required %h", i, got_s, exp_s);
      end
    end
    s_start = 1'b0;
    s_abort = 1'b0;

    exp_q.push_back('0);
    tick_and_score("idle_after_reset");

    run_main(1'b0, -1, 1'b0, "t1_zero_resp", last);
    run_main(1'b1, -1, 1'b0, "t2_loopback", last);
    run_main(1'b0, 40, 1'b0, "t3_abort", last);
    run_main(1'b0, -1, 1'b0, "t3_full", last);
    run_main(1'b1, -1, 1'b1, "t4_hold", last);
    start = 1'b0;
    exp_q.push_back(last);
    tick_and_score("t4_release");
    run_main(1'b0, -1, 1'b0, "t4_rerun", last);

    // Asynchronous reset between clock edges while START is held high.
    lb = 1'b1;
    start = 1'b1;
    exp_q.push_back({8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    tick_and_score("t5_c0");
    start = 1'b0;
    exp_q.push_back({8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01});
    tick_and_score("t5_c1");
    start = 1'b1;
    #2 rst = 1'b1;
    #1 check_obs("t5_async_reset", sample0(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      tick_and_score("t5_held_start");
    end
    start = 1'b0;
    exp_q.push_back('0);
    tick_and_score("t5_start_low");
    run_main(1'b0, -1, 1'b0, "t5_rerun", last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
